// File: rtl/sbus_quad_reader.sv
// SBUS quadword read requester for one MB20 memory phase: issues START/ADR/RQ,
// collects the returned words with parity checking and abandons the transfer if no acknowledge arrives.
module sbus_quad_reader #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic         clk,
    input  logic         CROBAR,
    input  logic         req,
    input  logic [14:35] reqAdr,
    input  logic [0:3]   reqRQ,
    output logic         ready,
    output logic         START,
    output logic [14:35] ADR,
    output logic [0:3]   RQ,
    input  logic         ACKN,
    input  logic         VALID,
    input  logic [0:35]  D,
    input  logic         DATA_PAR,
    output logic         rdValid,
    output logic [0:35]  rdData,
    output logic [34:35] rdWo,
    output logic         done,
    output logic         parErr,
    output logic         timeout,
    output logic         badRQ
);

    // state | meaning
    // IDLE  | ready for a request; ADR/RQ parked at 0
    // ISSUE | START driven for exactly one clock
    // XFER  | collecting words, timeout armed until the first word
    // FIN   | done pulse with parErr/timeout/badRQ
    typedef enum logic [1:0] {IDLE, ISSUE, XFER, FIN} state_t;

    state_t         state, nxt_state;
    logic [2:0]     n_left;
    logic [34:35]   wo;
    logic [TO_W-1:0] tmr;
    logic           got_word;
    logic           rq_legal;
    logic [2:0]     rq_cnt;
    logic           accept;
    logic           word;
    logic           to_hit;

    // Only a contiguous run of ones starting at word 0 is a legal request mask.
    always_comb begin
        rq_legal = 1'b1;
        rq_cnt   = 3'd0;
        case (reqRQ)
            4'b1000: rq_cnt = 3'd1;
            4'b1100: rq_cnt = 3'd2;
            4'b1110: rq_cnt = 3'd3;
            4'b1111: rq_cnt = 3'd4;
            default: rq_legal = 1'b0;
        endcase
    end

    assign accept = req && (state == IDLE);
    assign word   = (state == XFER) && (n_left != 3'd0) && (ACKN || VALID);
    assign to_hit = (state == XFER) && !got_word && !word && (tmr == '0);

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:  if (accept) nxt_state = rq_legal ? ISSUE : FIN;
            ISSUE: nxt_state = XFER;
            XFER:  if ((n_left == 3'd0) || to_hit) nxt_state = FIN;
            FIN:   nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        START = (state == ISSUE);
        ready = (state == IDLE) && !CROBAR;
        done  = (state == FIN);
    end

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            ADR      <= '0;
            RQ       <= '0;
            wo       <= '0;
            n_left   <= '0;
            tmr      <= '0;
            got_word <= 1'b0;
            rdValid  <= 1'b0;
            rdData   <= '0;
            rdWo     <= '0;
            parErr   <= 1'b0;
            timeout  <= 1'b0;
            badRQ    <= 1'b0;
        end else begin
            rdValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ADR    <= reqAdr;
                        RQ     <= reqRQ;
                        wo     <= reqAdr[34:35];
                        n_left <= rq_cnt;
                        badRQ  <= !rq_legal;
                    end
                end
                ISSUE: begin
                    tmr      <= TO_W'(TIMEOUT_CYCLES - 1);
                    got_word <= 1'b0;
                end
                XFER: begin
                    // ACKN alone still consumes a word slot but returns nothing.
                    if (word) begin
                        n_left   <= n_left - 3'd1;
                        got_word <= 1'b1;
                        if (VALID) begin
                            rdValid <= 1'b1;
                            rdData  <= D;
                            rdWo    <= wo;
                            wo      <= wo + 2'd1;
                            if (DATA_PAR != ^D) parErr <= 1'b1;
                        end
                    end else if (!got_word) begin
                        if (tmr == '0) timeout <= 1'b1;
                        else           tmr <= tmr - 1'b1;
                    end
                end
                FIN: begin
                    ADR     <= '0;
                    RQ      <= '0;
                    parErr  <= 1'b0;
                    timeout <= 1'b0;
                    badRQ   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
